// File: rtl/mips_ins_encoder_pkg.sv
// MIPS ISA constants shared with the decoder (mirror of mips_isa_defs.vh): opcodes, functs,
// REGIMM rt codes, mnemonic IDs 0..49 and the NOP word.
package mips_ins_encoder_pkg;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAddi    = 6'h08;
    localparam logic [5:0] OpAddiu   = 6'h09;
    localparam logic [5:0] OpSlti    = 6'h0a;
    localparam logic [5:0] OpSltiu   = 6'h0b;
    localparam logic [5:0] OpAndi    = 6'h0c;
    localparam logic [5:0] OpOri     = 6'h0d;
    localparam logic [5:0] OpXori    = 6'h0e;
    localparam logic [5:0] OpLui     = 6'h0f;
    localparam logic [5:0] OpLb      = 6'h20;
    localparam logic [5:0] OpLh      = 6'h21;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpLbu     = 6'h24;
    localparam logic [5:0] OpLhu     = 6'h25;
    localparam logic [5:0] OpSb      = 6'h28;
    localparam logic [5:0] OpSh      = 6'h29;
    localparam logic [5:0] OpSw      = 6'h2b;

    // SPECIAL funct codes
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnSra   = 6'h03;
    localparam logic [5:0] FnSllv  = 6'h04;
    localparam logic [5:0] FnSrlv  = 6'h06;
    localparam logic [5:0] FnSrav  = 6'h07;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnJalr  = 6'h09;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMthi  = 6'h11;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnMtlo  = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1a;
    localparam logic [5:0] FnDivu  = 6'h1b;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnXor   = 6'h26;
    localparam logic [5:0] FnNor   = 6'h27;
    localparam logic [5:0] FnSlt   = 6'h2a;
    localparam logic [5:0] FnSltu  = 6'h2b;

    // REGIMM rt codes
    localparam logic [4:0] RtBltz = 5'b00000;
    localparam logic [4:0] RtBgez = 5'b00001;

    // Mnemonic IDs
    localparam logic [5:0] MnAdd   = 6'd0;
    localparam logic [5:0] MnAddu  = 6'd1;
    localparam logic [5:0] MnSub   = 6'd2;
    localparam logic [5:0] MnSubu  = 6'd3;
    localparam logic [5:0] MnAnd   = 6'd4;
    localparam logic [5:0] MnOr    = 6'd5;
    localparam logic [5:0] MnXor   = 6'd6;
    localparam logic [5:0] MnNor   = 6'd7;
    localparam logic [5:0] MnSlt   = 6'd8;
    localparam logic [5:0] MnSltu  = 6'd9;
    localparam logic [5:0] MnSll   = 6'd10;
    localparam logic [5:0] MnSrl   = 6'd11;
    localparam logic [5:0] MnSra   = 6'd12;
    localparam logic [5:0] MnSllv  = 6'd13;
    localparam logic [5:0] MnSrlv  = 6'd14;
    localparam logic [5:0] MnSrav  = 6'd15;
    localparam logic [5:0] MnMult  = 6'd16;
    localparam logic [5:0] MnMultu = 6'd17;
    localparam logic [5:0] MnDiv   = 6'd18;
    localparam logic [5:0] MnDivu  = 6'd19;
    localparam logic [5:0] MnMfhi  = 6'd20;
    localparam logic [5:0] MnMflo  = 6'd21;
    localparam logic [5:0] MnMthi  = 6'd22;
    localparam logic [5:0] MnMtlo  = 6'd23;
    localparam logic [5:0] MnJr    = 6'd24;
    localparam logic [5:0] MnJalr  = 6'd25;
    localparam logic [5:0] MnAddi  = 6'd26;
    localparam logic [5:0] MnAddiu = 6'd27;
    localparam logic [5:0] MnAndi  = 6'd28;
    localparam logic [5:0] MnOri   = 6'd29;
    localparam logic [5:0] MnXori  = 6'd30;
    localparam logic [5:0] MnLui   = 6'd31;
    localparam logic [5:0] MnSlti  = 6'd32;
    localparam logic [5:0] MnSltiu = 6'd33;
    localparam logic [5:0] MnBeq   = 6'd34;
    localparam logic [5:0] MnBne   = 6'd35;
    localparam logic [5:0] MnBlez  = 6'd36;
    localparam logic [5:0] MnBgtz  = 6'd37;
    localparam logic [5:0] MnBltz  = 6'd38;
    localparam logic [5:0] MnBgez  = 6'd39;
    localparam logic [5:0] MnJ     = 6'd40;
    localparam logic [5:0] MnJal   = 6'd41;
    localparam logic [5:0] MnLb    = 6'd42;
    localparam logic [5:0] MnLbu   = 6'd43;
    localparam logic [5:0] MnLh    = 6'd44;
    localparam logic [5:0] MnLhu   = 6'd45;
    localparam logic [5:0] MnLw    = 6'd46;
    localparam logic [5:0] MnSb    = 6'd47;
    localparam logic [5:0] MnSh    = 6'd48;
    localparam logic [5:0] MnSw    = 6'd49;

    localparam int unsigned NumMnem = 50;
    localparam logic [31:0] NopWord = 32'h0000_0000;

    // Control-transfer mnemonics, i.e. those followed by a delay slot
    function automatic logic is_branch_mnem(input logic [5:0] mnem);
        return mnem inside {MnBeq, MnBne, MnBlez, MnBgtz, MnBltz, MnBgez,
                            MnJ, MnJal, MnJr, MnJalr};
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO for encoded instruction words with registered occupancy and
// full/empty/free-slot status.
module ins_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  free_o
);

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthC);
    assign empty_o = (count_q == '0);
    assign free_o  = DepthC - count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + AddrW'(do_push);
        rd_ptr_d = rd_ptr_q + AddrW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mips_ins_encoder.sv
// Encodes mnemonic requests into MIPS words and streams them to instruction memory.
// Optional delay-slot NOP insertion via MIPS_ENC_DSLOT_NOP_EN.
module mips_ins_encoder
    import mips_ins_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_data,
    input  logic        im_ready,
    output logic        err_illegal,
    output logic [15:0] word_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [5:0]  op, funct;
    logic [4:0]  enc_rs, enc_rt, enc_rd, enc_sh;
    logic        r_type, j_type, legal;
    logic [31:0] enc_word;

    always_comb begin
        op     = OpSpecial;
        funct  = '0;
        enc_rs = in_rs;
        enc_rt = in_rt;
        enc_rd = in_rd;
        enc_sh = '0;
        r_type = 1'b0;
        j_type = 1'b0;
        legal  = 1'b1;
        case (in_mnem)
            MnAdd:   begin r_type = 1'b1; funct = FnAdd;  end
            MnAddu:  begin r_type = 1'b1; funct = FnAddu; end
            MnSub:   begin r_type = 1'b1; funct = FnSub;  end
            MnSubu:  begin r_type = 1'b1; funct = FnSubu; end
            MnAnd:   begin r_type = 1'b1; funct = FnAnd;  end
            MnOr:    begin r_type = 1'b1; funct = FnOr;   end
            MnXor:   begin r_type = 1'b1; funct = FnXor;  end
            MnNor:   begin r_type = 1'b1; funct = FnNor;  end
            MnSlt:   begin r_type = 1'b1; funct = FnSlt;  end
            MnSltu:  begin r_type = 1'b1; funct = FnSltu; end
            MnSll:   begin r_type = 1'b1; funct = FnSll; enc_sh = in_shamt; end
            MnSrl:   begin r_type = 1'b1; funct = FnSrl; enc_sh = in_shamt; end
            MnSra:   begin r_type = 1'b1; funct = FnSra; enc_sh = in_shamt; end
            MnSllv:  begin r_type = 1'b1; funct = FnSllv; end
            MnSrlv:  begin r_type = 1'b1; funct = FnSrlv; end
            MnSrav:  begin r_type = 1'b1; funct = FnSrav; end
            MnMult:  begin r_type = 1'b1; funct = FnMult;  enc_rd = '0; end
            MnMultu: begin r_type = 1'b1; funct = FnMultu; enc_rd = '0; end
            MnDiv:   begin r_type = 1'b1; funct = FnDiv;   enc_rd = '0; end
            MnDivu:  begin r_type = 1'b1; funct = FnDivu;  enc_rd = '0; end
            MnMfhi:  begin r_type = 1'b1; funct = FnMfhi; enc_rs = '0; enc_rt = '0; end
            MnMflo:  begin r_type = 1'b1; funct = FnMflo; enc_rs = '0; enc_rt = '0; end
            MnMthi:  begin r_type = 1'b1; funct = FnMthi; enc_rt = '0; enc_rd = '0; end
            MnMtlo:  begin r_type = 1'b1; funct = FnMtlo; enc_rt = '0; enc_rd = '0; end
            MnJr:    begin r_type = 1'b1; funct = FnJr;   enc_rt = '0; enc_rd = '0; end
            MnJalr:  begin r_type = 1'b1; funct = FnJalr; enc_rt = '0; end
            MnAddi:  op = OpAddi;
            MnAddiu: op = OpAddiu;
            MnAndi:  op = OpAndi;
            MnOri:   op = OpOri;
            MnXori:  op = OpXori;
            MnLui:   begin op = OpLui; enc_rs = '0; end
            MnSlti:  op = OpSlti;
            MnSltiu: op = OpSltiu;
            MnBeq:   op = OpBeq;
            MnBne:   op = OpBne;
            MnBlez:  begin op = OpBlez;   enc_rt = '0;     end
            MnBgtz:  begin op = OpBgtz;   enc_rt = '0;     end
            MnBltz:  begin op = OpRegimm; enc_rt = RtBltz; end
            MnBgez:  begin op = OpRegimm; enc_rt = RtBgez; end
            MnJ:     begin op = OpJ;   j_type = 1'b1; end
            MnJal:   begin op = OpJal; j_type = 1'b1; end
            MnLb:    op = OpLb;
            MnLbu:   op = OpLbu;
            MnLh:    op = OpLh;
            MnLhu:   op = OpLhu;
            MnLw:    op = OpLw;
            MnSb:    op = OpSb;
            MnSh:    op = OpSh;
            MnSw:    op = OpSw;
            default: legal = 1'b0;
        endcase
        if (j_type) begin
            enc_word = {op, in_target};
        end else if (r_type) begin
            enc_word = {OpSpecial, enc_rs, enc_rt, enc_rd, enc_sh, funct};
        end else begin
            enc_word = {op, enc_rs, enc_rt, in_imm};
        end
    end

    logic            accept, push, pop;
    logic [31:0]     push_data, fifo_head;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_free;

    assign accept = in_valid && in_ready;

`ifdef MIPS_ENC_DSLOT_NOP_EN
    logic nop_pend_q, nop_pend_d;

    // Two free slots guarantee room for a branch and its trailing NOP
    assign in_ready   = (fifo_free >= CntW'(2)) && !nop_pend_q;
    assign nop_pend_d = accept && legal && is_branch_mnem(in_mnem);
    assign push       = nop_pend_q || (accept && legal);
    assign push_data  = nop_pend_q ? NopWord : enc_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            nop_pend_q <= 1'b0;
        end else begin
            nop_pend_q <= nop_pend_d;
        end
    end
`else
    assign in_ready  = !fifo_full;
    assign push      = accept && legal;
    assign push_data = enc_word;
`endif

    ins_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .free_o      (fifo_free)
    );

    always_comb begin
        assert (fifo_full == (fifo_free == '0));
    end

    assign im_we   = !fifo_empty;
    assign im_data = fifo_empty ? '0 : fifo_head;
    assign pop     = im_we && im_ready;

    logic [31:0] im_addr_q, im_addr_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        err_q, err_d;

    always_comb begin
        im_addr_d  = im_addr_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q || (accept && !legal);
        if (pop) begin
            im_addr_d = im_addr_q + 32'd4;
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_addr_q  <= BASE_ADDR;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            im_addr_q  <= im_addr_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    assign im_addr     = im_addr_q;
    assign word_cnt    = word_cnt_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_ins_encoder.sv
// Self-checking bench for mips_ins_encoder: directed vectors plus randomized traffic
// against a table-driven reference model and a word scoreboard.
module tb_mips_ins_encoder;
    import mips_ins_encoder_pkg::*;

    localparam int DEPTH = 4;
`ifdef MIPS_ENC_DSLOT_NOP_EN
    localparam int EXP_FILL = DEPTH - 1;
`else
    localparam int EXP_FILL = DEPTH;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, im_we, im_ready, err_illegal;
    logic [5:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm, word_cnt;
    logic [25:0] in_target;
    logic [31:0] im_addr, im_data;

    mips_ins_encoder #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_shamt    (in_shamt),
        .in_imm      (in_imm),
        .in_target   (in_target),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .im_ready    (im_ready),
        .err_illegal (err_illegal),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference tables: field usage per instruction class
    localparam int KR3 = 0, KSH = 1, KRS = 2, KRD = 3, KRSRD = 4, KRSRT = 5;
    localparam int KI = 6, KLUI = 7, KBZ = 8, KJ = 9;
    int unsigned tab_op[50], tab_fn[50], tab_kind[50], tab_rtv[50];
    bit          tab_br[50];

    task automatic def(input int id, input int op, input int fn, input int kind,
                       input int rtv, input bit br);
        tab_op[id] = op; tab_fn[id] = fn; tab_kind[id] = kind;
        tab_rtv[id] = rtv; tab_br[id] = br;
    endtask

    task automatic init_tables();
        def(MnAdd,  0, 'h20, KR3, 0, 0);  def(MnAddu, 0, 'h21, KR3, 0, 0);
        def(MnSub,  0, 'h22, KR3, 0, 0);  def(MnSubu, 0, 'h23, KR3, 0, 0);
        def(MnAnd,  0, 'h24, KR3, 0, 0);  def(MnOr,   0, 'h25, KR3, 0, 0);
        def(MnXor,  0, 'h26, KR3, 0, 0);  def(MnNor,  0, 'h27, KR3, 0, 0);
        def(MnSlt,  0, 'h2a, KR3, 0, 0);  def(MnSltu, 0, 'h2b, KR3, 0, 0);
        def(MnSll,  0, 'h00, KSH, 0, 0);  def(MnSrl,  0, 'h02, KSH, 0, 0);
        def(MnSra,  0, 'h03, KSH, 0, 0);  def(MnSllv, 0, 'h04, KR3, 0, 0);
        def(MnSrlv, 0, 'h06, KR3, 0, 0);  def(MnSrav, 0, 'h07, KR3, 0, 0);
        def(MnMult, 0, 'h18, KRSRT, 0, 0); def(MnMultu, 0, 'h19, KRSRT, 0, 0);
        def(MnDiv,  0, 'h1a, KRSRT, 0, 0); def(MnDivu,  0, 'h1b, KRSRT, 0, 0);
        def(MnMfhi, 0, 'h10, KRD, 0, 0);  def(MnMflo, 0, 'h12, KRD, 0, 0);
        def(MnMthi, 0, 'h11, KRS, 0, 0);  def(MnMtlo, 0, 'h13, KRS, 0, 0);
        def(MnJr,   0, 'h08, KRS, 0, 1);  def(MnJalr, 0, 'h09, KRSRD, 0, 1);
        def(MnAddi, 'h08, 0, KI, 0, 0);   def(MnAddiu, 'h09, 0, KI, 0, 0);
        def(MnAndi, 'h0c, 0, KI, 0, 0);   def(MnOri,   'h0d, 0, KI, 0, 0);
        def(MnXori, 'h0e, 0, KI, 0, 0);   def(MnLui,   'h0f, 0, KLUI, 0, 0);
        def(MnSlti, 'h0a, 0, KI, 0, 0);   def(MnSltiu, 'h0b, 0, KI, 0, 0);
        def(MnBeq,  'h04, 0, KI, 0, 1);   def(MnBne,   'h05, 0, KI, 0, 1);
        def(MnBlez, 'h06, 0, KBZ, 0, 1);  def(MnBgtz,  'h07, 0, KBZ, 0, 1);
        def(MnBltz, 'h01, 0, KBZ, 0, 1);  def(MnBgez,  'h01, 0, KBZ, 1, 1);
        def(MnJ,    'h02, 0, KJ, 0, 1);   def(MnJal,   'h03, 0, KJ, 0, 1);
        def(MnLb,   'h20, 0, KI, 0, 0);   def(MnLbu,   'h24, 0, KI, 0, 0);
        def(MnLh,   'h21, 0, KI, 0, 0);   def(MnLhu,   'h25, 0, KI, 0, 0);
        def(MnLw,   'h23, 0, KI, 0, 0);   def(MnSb,    'h28, 0, KI, 0, 0);
        def(MnSh,   'h29, 0, KI, 0, 0);   def(MnSw,    'h2b, 0, KI, 0, 0);
    endtask

    function automatic logic [31:0] model_word(input int unsigned m, input int unsigned rs,
            input int unsigned rt, input int unsigned rd, input int unsigned sh,
            input int unsigned imm, input int unsigned tgt);
        int unsigned k, f_rs, f_rt, f_rd, f_sh;
        k = tab_kind[m];
        if (k == KJ) return tab_op[m] * 32'd67108864 + tgt;
        if (k >= KI) begin
            f_rs = (k == KLUI) ? 0 : rs;
            f_rt = (k == KBZ) ? tab_rtv[m] : rt;
            return tab_op[m] * 32'd67108864 + f_rs * 32'd2097152 + f_rt * 32'd65536 + imm;
        end
        f_rs = (k == KRD) ? 0 : rs;
        f_rt = (k == KRS || k == KRD || k == KRSRD) ? 0 : rt;
        f_rd = (k == KRS || k == KRSRT) ? 0 : rd;
        f_sh = (k == KSH) ? sh : 0;
        return f_rs * 32'd2097152 + f_rt * 32'd65536 + f_rd * 32'd2048 + f_sh * 32'd64
               + tab_fn[m];
    endfunction

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = 32'h0000_3000;
    int          exp_cnt  = 0;
    bit          exp_err  = 0;
    bit          nop_pend = 0;
    bit          mon_en   = 0;
    bit          exp_ready;
    int          exp_size;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_size = exp_q.size();
`ifdef MIPS_ENC_DSLOT_NOP_EN
            exp_ready = (exp_size <= DEPTH - 2) && !nop_pend;
`else
            exp_ready = exp_size < DEPTH;
`endif
            check_eq("in_ready", in_ready, exp_ready);
            check_eq("im_we", im_we, exp_size != 0);
            check_eq("im_addr", im_addr, exp_addr);
            check_eq("word_cnt", word_cnt, exp_cnt);
            check_eq("err_illegal", err_illegal, exp_err);
            if (exp_size != 0) check_eq("im_data", im_data, exp_q[0]);
            if (!reset) begin
                exp_q.delete();
                exp_addr = 32'h0000_3000;
                exp_cnt  = 0;
                exp_err  = 0;
                nop_pend = 0;
            end else begin
                if (exp_size != 0 && im_ready) begin
                    void'(exp_q.pop_front());
                    exp_addr = exp_addr + 4;
                    if (exp_cnt < 65535) exp_cnt++;
                end
                if (nop_pend) begin
                    exp_q.push_back(32'h0);
                    nop_pend = 0;
                end
                if (in_valid && exp_ready) begin
                    if (in_mnem < 50) begin
                        exp_q.push_back(model_word(in_mnem, in_rs, in_rt, in_rd, in_shamt,
                                                   in_imm, in_target));
`ifdef MIPS_ENC_DSLOT_NOP_EN
                        nop_pend = tab_br[in_mnem];
`endif
                    end else begin
                        exp_err = 1;
                    end
                end
            end
        end
    end

    task automatic drive_req(input int m, input int rs, input int rt, input int rd,
                             input int sh, input int imm, input int tgt);
        in_mnem = 6'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int sh, input int imm);
        bit done = 0;
        drive_req(m, rs, rt, rd, sh, imm, 0);
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin done = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!done) check_eq("send_timeout", 0, 1);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] word,
                               input logic [31:0] addr);
        bit seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (im_we) begin seen = 1; break; end
        end
        if (seen) begin
            check_eq(tag, im_data, word);
            check_eq({tag, "_addr"}, im_addr, addr);
        end else begin
            check_eq({tag, "_timeout"}, 0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit empty = 0;
        im_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!im_we) begin empty = 1; break; end
        end
        @(posedge clk); #1;
        im_ready = 1'b0;
        if (!empty) check_eq("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        init_tables();
        reset = 1'b0; in_valid = 1'b0; im_ready = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        mon_en = 1;
        @(posedge clk); #1;
        check_eq("rst_im_we", im_we, 0);
        check_eq("rst_im_addr", im_addr, 32'h0000_3000);
        check_eq("rst_im_data", im_data, 0);
        check_eq("rst_err", err_illegal, 0);
        check_eq("rst_cnt", word_cnt, 0);
        reset = 1'b1;

        send(MnAddu, 1, 2, 3, 0, 0);
        expect_head("addu", 32'h0022_1821, 32'h0000_3000);
        drain();
        send(MnOri, 0, 1, 0, 0, 'h1234);
        expect_head("ori", 32'h3401_1234, 32'h0000_3004);
        drain();
        send(MnLui, 5, 4, 0, 0, 'hFFFF);
        expect_head("lui", 32'h3C04_FFFF, 32'h0000_3008);
        drain();
        send(MnBgez, 2, 7, 0, 0, 3);
        expect_head("bgez", 32'h0441_0003, 32'h0000_300C);
`ifdef MIPS_ENC_DSLOT_NOP_EN
        im_ready = 1'b1;
        @(posedge clk); #1;
        im_ready = 1'b0;
        expect_head("dslot_nop", 32'h0000_0000, 32'h0000_3010);
`endif
        drain();

        // Back-pressure: fill with im_ready low, then release
        do_reset();
        accepts = 0;
        for (int i = 0; i < 8 && accepts < 6; i++) begin
            drive_req(MnAddu, i, i + 1, i + 2, 0, 0, 0);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) break;
            accepts++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("fill_accepts", accepts, EXP_FILL);
        check_eq("full_in_ready", in_ready, 0);
        im_ready = 1'b1;
        for (int i = accepts; i < 6; i++) send(MnAddu, i, i + 1, i + 2, 0, 0);
        drain();
        check_eq("word_cnt6", word_cnt, 6);

        // Illegal ID consumed without a push
        im_ready = 1'b1;
        send(63, 1, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("illegal_err", err_illegal, 1);
        check_eq("illegal_we", im_we, 0);
        check_eq("illegal_addr", im_addr, 32'h0000_3018);
        im_ready = 1'b0;
        send(MnAddu, 4, 5, 9, 0, 0);
        expect_head("post_illegal", 32'h0085_4821, 32'h0000_3018);
        drain();

        // Reset with words buffered
        send(MnAddu, 1, 1, 1, 0, 0);
        send(MnSubu, 2, 2, 2, 0, 0);
        send(MnOr, 3, 3, 3, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_buf_we", im_we, 0);
        check_eq("rst_buf_addr", im_addr, 32'h0000_3000);
        check_eq("rst_buf_cnt", word_cnt, 0);
        check_eq("rst_buf_err", err_illegal, 0);
        reset = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            im_ready = ($urandom_range(0, 2) != 0);
            drive_req(($urandom_range(0, 15) == 0) ? 50 + $urandom_range(0, 13)
                                                   : $urandom_range(0, 49),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 65535),
                      $urandom_range(0, 26'h3FF_FFFF));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        check_eq("final_empty", im_we, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
